// File: rtl/demux_stream_1n.sv
// rtl/demux_stream_1n.sv - registered 1-to-N stream demultiplexer with per-channel holding registers
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   mode                              : 0 = addressed (in_sel picks channel), 1 = round-robin (rr_ptr picks)
//   in_valid, in_data, in_sel         : input beat, payload and addressed-mode target
//   in_ready                          : beat accepted this cycle (combinational, independent of in_valid)
//   out_valid, out_data, out_ready    : N output channels, channel k at out_data[k*WIDTH +: WIDTH]
//   rr_ptr                            : round-robin pointer, cycles 0..N-1
//   sel_err                           : one-cycle pulse after a beat with an out-of-range target is dropped
module demux_stream_1n #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [SEL_W-1:0]     in_sel,
   output logic                 in_ready,
   output logic [N-1:0]         out_valid,
   output logic [N*WIDTH-1:0]   out_data,
   input  logic [N-1:0]         out_ready,
   output logic [SEL_W-1:0]     rr_ptr,
   output logic                 sel_err
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

   logic [SEL_W-1:0] tgt;
   logic [N-1:0]     hit;
   logic             tgt_blocked;
   logic             xfer;

   // One-hot decode of the target; an out-of-range target leaves hit all zero.
   always_comb begin
      tgt = mode ? rr_ptr : in_sel;
      hit = '0;
      for (int k = 0; k < N; k++) begin
         hit[k] = (tgt == SEL_W'(k));
      end
   end

   // Only a full, non-draining target channel stalls the input; a dropped
   // (out-of-range) beat is always accepted so it cannot wedge the stream.
   assign tgt_blocked = |(hit & out_valid & ~out_ready);
   assign in_ready    = !rst && !tgt_blocked;
   assign xfer        = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= '0;
         out_data  <= '0;
         rr_ptr    <= '0;
         sel_err   <= 1'b0;
      end else begin
         sel_err <= xfer && (hit == '0);
         for (int k = 0; k < N; k++) begin
            // Load takes precedence over drain so a channel sustains 1 beat/cycle.
            if (xfer && hit[k]) begin
               out_valid[k]               <= 1'b1;
               out_data[k*WIDTH +: WIDTH] <= in_data;
            end else if (out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
         // Wrap at N-1 rather than at 2^SEL_W so the pointer never leaves range.
         if (xfer && mode) begin
            rr_ptr <= (rr_ptr == LAST) ? '0 : rr_ptr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_demux_stream_1n.sv
// tb/tb_demux_stream_1n.sv - scoreboard bench for demux_stream_1n with a queue-based reference model
module tb_demux_stream_1n;
   localparam int WIDTH = 8;
   localparam int N     = 3;
   localparam int SEL_W = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               mode;
   logic               in_valid;
   logic [WIDTH-1:0]   in_data;
   logic [SEL_W-1:0]   in_sel;
   logic               in_ready;
   logic [N-1:0]       out_valid;
   logic [N*WIDTH-1:0] out_data;
   logic [N-1:0]       out_ready;
   logic [SEL_W-1:0]   rr_ptr;
   logic               sel_err;

   always #5 clk = ~clk;

   demux_stream_1n #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .rr_ptr    (rr_ptr),
      .sel_err   (sel_err)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: each channel is a queue of beats awaiting the consumer.
   logic [WIDTH-1:0] sb [N][$];
   int  model_rr    = 0;
   bit  exp_ready   = 1'b0;
   bit  exp_xfer    = 1'b0;
   bit  exp_sel_err = 1'b0;
   int  exp_tgt     = 0;
   bit  done        = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus, predict acceptance, then update the model after the edge.
   task automatic cycle(input bit r, input bit m, input bit v, input logic [WIDTH-1:0] d,
                        input logic [SEL_W-1:0] s, input logic [N-1:0] ordy);
      bit blocked;
      rst = r; mode = m; in_valid = v; in_data = d; in_sel = s; out_ready = ordy;
      #1;
      exp_tgt = m ? model_rr : int'(s);
      blocked = 1'b0;
      if (exp_tgt < N) begin
         if (sb[exp_tgt].size() != 0 && !ordy[exp_tgt]) blocked = 1'b1;
      end
      exp_ready = !r && !blocked;
      exp_xfer  = v && exp_ready;
      @(negedge clk);
      #1;
      if (r) begin
         for (int k = 0; k < N; k++) sb[k].delete();
         model_rr    = 0;
         exp_sel_err = 1'b0;
      end else begin
         exp_sel_err = exp_xfer && (exp_tgt >= N);
         if (exp_xfer && exp_tgt < N) sb[exp_tgt].push_back(d);
         if (exp_xfer && m) model_rr = (model_rr + 1) % N;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares handshake/status outputs and pops beats as consumers take them.
   initial begin : monitor
      logic [WIDTH-1:0] e;
      @(negedge clk);
      while (!done) begin
         chk("in_ready", in_ready, exp_ready);
         chk("rr_ptr", rr_ptr, model_rr);
         chk("sel_err", sel_err, exp_sel_err);
         for (int k = 0; k < N; k++) begin
            chk($sformatf("out_valid[%0d]", k), out_valid[k], sb[k].size() != 0);
            if (!rst && out_valid[k] && out_ready[k]) begin
               if (sb[k].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_beat[%0d]: got %0h expected none", k, out_data[k*WIDTH +: WIDTH]);
               end else begin
                  e = sb[k].pop_front();
                  chk($sformatf("out_data[%0d]", k), out_data[k*WIDTH +: WIDTH], e);
               end
            end
         end
         @(negedge clk);
      end
   end

   initial begin : driver
      // Reset held with a pending beat: nothing may be accepted.
      cycle(1, 0, 1, 8'hFF, 2'd0, 3'b111);
      cycle(1, 0, 1, 8'hFF, 2'd1, 3'b111);
      // Addressed fan-out, then an out-of-range select.
      for (int i = 0; i < N; i++) cycle(0, 0, 1, 8'hA0 + 8'(i), 2'(i), 3'b111);
      cycle(0, 0, 1, 8'h5A, 2'd3, 3'b111);
      cycle(0, 0, 0, 8'h00, 2'd0, 3'b111);
      // Back-pressure on channel 2 while channel 1 still flows.
      cycle(0, 0, 1, 8'h11, 2'd2, 3'b011);
      cycle(0, 0, 1, 8'h22, 2'd2, 3'b011);
      cycle(0, 0, 1, 8'h33, 2'd1, 3'b011);
      cycle(0, 0, 1, 8'h22, 2'd2, 3'b111);
      cycle(0, 0, 0, 8'h00, 2'd0, 3'b111);
      // Round-robin wrap over N channels.
      for (int i = 0; i < 7; i++) cycle(0, 1, 1, 8'h70 + 8'(i), 2'd3, 3'b111);
      // Mode switch: pointer is held while addressed, resumes afterwards.
      cycle(1, 0, 0, 8'h00, 2'd0, 3'b111);
      cycle(0, 1, 1, 8'hB0, 2'd0, 3'b111);
      cycle(0, 1, 1, 8'hB1, 2'd0, 3'b111);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'hC0 + 8'(i), 2'(i), 3'b111);
      cycle(0, 1, 1, 8'hB2, 2'd0, 3'b111);
      // Fill every channel, then reset mid-stream.
      for (int i = 0; i < N; i++) cycle(0, 0, 1, 8'hD0 + 8'(i), 2'(i), 3'b000);
      cycle(1, 0, 1, 8'hEE, 2'd0, 3'b000);
      cycle(0, 0, 0, 8'h00, 2'd0, 3'b000);
      // Randomised traffic.
      for (int i = 0; i < 800; i++) begin
         cycle(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
               8'($urandom), 2'($urandom), 3'($urandom | $urandom));
      end
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 2'd0, 3'b111);
      done = 1'b1;
      @(negedge clk);
      for (int k = 0; k < N; k++) chk($sformatf("leftover[%0d]", k), sb[k].size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demux_stream_1n.md
# demux_stream_1n

Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshakes on every port. Each input beat goes to one output channel, chosen either by an explicit select or by an internal round-robin pointer. Each output channel has a one-entry holding register, so a stalled channel does not block beats bound for a free one. It generalises the combinational 1-to-4 demux to any width and channel count, and adds back-pressure and sequential distribution.

## Interface
- `WIDTH`, 8, data bits per beat.
- `N`, 4, number of output channels; 2..16.
- `SEL_W`, 2, select width; must satisfy 2^SEL_W >= N.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = addressed (use `in_sel`), 1 = round-robin (internal pointer).
- `in_valid`  in  1  input beat present.
- `in_data`  in  WIDTH  input payload.
- `in_sel`  in  SEL_W  target channel in addressed mode; ignored in round-robin mode.
- `in_ready`  out  1  block accepts the beat this cycle.
- `out_valid`  out  N  per-channel holding register full.
- `out_data`  out  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `out_ready`  in  N  per-channel consumer ready.
- `rr_ptr`  out  SEL_W  current round-robin pointer.
- `sel_err`  out  1  one-cycle pulse when a beat is discarded for an out-of-range select.

## Operation
- Target `t`:
  - `t = in_sel` when `mode` = 0.
  - `t = rr_ptr` when `mode` = 1.
- Acceptance: `in_ready` = !`rst` && (t >= N || !`out_valid[t]` || `out_ready[t]`). This is combinational from `mode`, `in_sel`, `rr_ptr`, `out_valid` and `out_ready`. It must not depend on `in_valid`.
- Beat transfer occurs when `in_valid` && `in_ready`.
- On transfer with t < N: `out_data[t]` <= `in_data`, and `out_valid[t]` <= 1.
- On transfer with t >= N (addressed mode only):
  - The beat is consumed and dropped.
  - `sel_err` <= 1 for one cycle.
  - No channel state changes.
- Channel drain: when `out_valid[k]` && `out_ready[k]` and channel k receives no new transfer, `out_valid[k]` <= 0. `out_data[k]` holds its last value.
- Drain and load in the same cycle on the same channel: the load wins. `out_valid` stays 1 and the data is replaced. This gives full throughput of 1 beat/cycle per channel.
- Channels are independent. Any number may drain in the same cycle.
- Round-robin pointer:
  - Advances only on a transfer while `mode` = 1.
  - Sequence is 0,1,...,N-1,0 and wraps at N-1, not at 2^SEL_W.
  - Holds while stalled: `in_valid` low, or target channel full and not draining.
  - Never visits values >= N, so `sel_err` cannot fire in `mode` = 1.
- Mode switching:
  - `mode` may change on any cycle.
  - `rr_ptr` holds its value while `mode` = 0 and resumes from that value when `mode` returns to 1.
  - Beats already held in channels are unaffected.
- Reset, synchronous and taking priority over everything:
  - `out_valid` = 0, `out_data` = 0, `rr_ptr` = 0, `sel_err` = 0.
  - `in_ready` = 0 while `rst` is high.
  - Reset asserted mid-stream discards all held beats, and no transfer occurs in that cycle.

## Timing
- Latency: a beat accepted at edge E is visible on `out_valid[t]`/`out_data[t]` immediately after E. That is one cycle from input to output.
- Earliest consumer handshake is the cycle after acceptance.
- `in_ready` has a combinational path from `out_ready`. There is no combinational path from `in_valid`/`in_data` to any output.
- `sel_err` is high for exactly the cycle after the dropped beat's edge.
- First acceptance after reset is possible in the first cycle with `rst` low.
- Sustained throughput is 1 beat/cycle whenever the target consumer holds `out_ready` high.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid` = 1 -> `in_ready` = 0, `out_valid` = 4'b0000, `rr_ptr` = 0, no transfer.
- Addressed, WIDTH=8, N=4, all `out_ready` = 1: send 0xA0..0xA3 with `in_sel` = 0..3 on consecutive cycles -> each `out_valid[k]` pulses one cycle after its beat with `out_data[k]` = 0xA0+k, and `in_ready` stays 1.
- Back-pressure: `out_ready[2]` = 0, send 0x11 then 0x22 to channel 2 -> 0x11 held, `in_ready` = 0 on the second beat. Then send 0x33 to channel 1 -> it is accepted. Raise `out_ready[2]` -> 0x11 drains, 0x22 loads in the same cycle, and `out_valid[2]` stays 1.
- Round-robin wrap: `mode` = 1, N=3, SEL_W=2, 7 consecutive beats, all ready -> channel order 0,1,2,0,1,2,0 and `rr_ptr` never equals 3.
- Out-of-range: N=3, `mode` = 0, `in_sel` = 3, `in_data` = 0x5A -> `in_ready` = 1, `sel_err` pulses once, `out_valid` unchanged.
- Mode switch plus mid-stream reset: in round-robin, send 2 beats (`rr_ptr` = 2), switch to addressed for 3 beats, then return to round-robin -> next beat goes to channel 2. Assert `rst` with channels full -> all `out_valid` = 0 on the next cycle.
